// File: rtl/ifid_lmsm_expander.sv
// IF/ID pipeline register for IITB-RISC-23 with LM/SM micro-op expansion.
// Each selected register of an LM/SM is presented to decode as its own micro-op while fetch is held.
module ifid_lmsm_expander (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_f,
  input  logic [15:0] pc2_f,
  input  logic [15:0] instr_f,
  input  logic        stall_in,
  input  logic        flush,
  output logic        pc_we,
  output logic        valid_d,
  output logic [15:0] pc_d,
  output logic [15:0] pc2_d,
  output logic [15:0] instr_d,
  output logic        multi_d,
  output logic [2:0]  mreg_d,
  output logic [15:0] mem_ofs_d,
  output logic        multi_last_d
);

  typedef enum logic {NORMAL, SEQ} seq_e;

  seq_e        seq_q, seq_n;
  logic        valid_q, valid_n;
  logic        multi_q, multi_n;
  logic [15:0] pc_q, pc_n;
  logic [15:0] pc2_q, pc2_n;
  logic [15:0] instr_q, instr_n;
  logic [7:0]  rem_q, rem_n;
  logic [15:0] ofs_q, ofs_n;

  logic [2:0]  mreg_cur;
  logic [7:0]  emit_mask;
  logic [3:0]  rem_cnt;
  logic [3:0]  bmp_cnt;
  logic        is_lmsm_f;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // Bit (7-i) selects Ri, so the lowest-indexed register is the highest set bit.
  always_comb begin
    mreg_cur = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_q[7-i]) mreg_cur = 3'(i);
    end
    emit_mask = 8'b1000_0000 >> mreg_cur;
    rem_cnt   = popcount8(rem_q);
    bmp_cnt   = popcount8(instr_f[7:0]);
    is_lmsm_f = (instr_f[15:12] == 4'b0110) || (instr_f[15:12] == 4'b0111);
  end

  always_comb begin
    seq_n   = seq_q;
    valid_n = valid_q;
    multi_n = multi_q;
    pc_n    = pc_q;
    pc2_n   = pc2_q;
    instr_n = instr_q;
    rem_n   = rem_q;
    ofs_n   = ofs_q;
    pc_we   = 1'b0;
    if (flush) begin
      seq_n   = NORMAL;
      valid_n = 1'b0;
      multi_n = 1'b0;
      pc_n    = 16'd0;
      pc2_n   = 16'd0;
      instr_n = 16'd0;
      rem_n   = 8'd0;
      ofs_n   = 16'd0;
      pc_we   = 1'b1;
    end else if (stall_in) begin
      pc_we = 1'b0;
    end else if (seq_q == SEQ) begin
      // SEQ always has at least two registers left, so this is never the last micro-op.
      rem_n = rem_q & ~emit_mask;
      ofs_n = ofs_q + 16'd2;
      if (rem_cnt == 4'd2) seq_n = NORMAL;
    end else begin
      pc_we   = 1'b1;
      pc_n    = pc_f;
      pc2_n   = pc2_f;
      instr_n = instr_f;
      ofs_n   = 16'd0;
      seq_n   = NORMAL;
      if (is_lmsm_f && (bmp_cnt != 4'd0)) begin
        valid_n = 1'b1;
        multi_n = 1'b1;
        rem_n   = instr_f[7:0];
        if (bmp_cnt > 4'd1) seq_n = SEQ;
      end else if (is_lmsm_f) begin
        valid_n = 1'b0;
        multi_n = 1'b0;
        rem_n   = 8'd0;
      end else begin
        valid_n = 1'b1;
        multi_n = 1'b0;
        rem_n   = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q   <= NORMAL;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      pc_q    <= 16'd0;
      pc2_q   <= 16'd0;
      instr_q <= 16'd0;
      rem_q   <= 8'd0;
      ofs_q   <= 16'd0;
    end else begin
      seq_q   <= seq_n;
      valid_q <= valid_n;
      multi_q <= multi_n;
      pc_q    <= pc_n;
      pc2_q   <= pc2_n;
      instr_q <= instr_n;
      rem_q   <= rem_n;
      ofs_q   <= ofs_n;
    end
  end

  assign valid_d      = valid_q;
  assign pc_d         = pc_q;
  assign pc2_d        = pc2_q;
  assign instr_d      = instr_q;
  assign multi_d      = multi_q;
  assign mreg_d       = multi_q ? mreg_cur : 3'd0;
  assign mem_ofs_d    = multi_q ? ofs_q : 16'd0;
  assign multi_last_d = multi_q && (rem_cnt == 4'd1);

endmodule

// File: tb/tb_ifid_lmsm_expander.sv
// Directed bench for ifid_lmsm_expander: reset, straight-line flow, LM/SM expansion, stall, flush, zero bitmap.
module tb_ifid_lmsm_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_f, pc2_f, instr_f;
  logic        stall_in, flush;
  logic        pc_we, valid_d, multi_d, multi_last_d;
  logic [15:0] pc_d, pc2_d, instr_d, mem_ofs_d;
  logic [2:0]  mreg_d;

  int checks = 0;
  int failures = 0;

  ifid_lmsm_expander dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pc2_f(pc2_f), .instr_f(instr_f),
    .stall_in(stall_in), .flush(flush), .pc_we(pc_we), .valid_d(valid_d),
    .pc_d(pc_d), .pc2_d(pc2_d), .instr_d(instr_d), .multi_d(multi_d),
    .mreg_d(mreg_d), .mem_ofs_d(mem_ofs_d), .multi_last_d(multi_last_d)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] pc, input logic [15:0] instr,
                               input logic stall, input logic fl);
    pc_f     = pc;
    pc2_f    = pc + 16'd2;
    instr_f  = instr;
    stall_in = stall;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks every micro-op field of the held register in one call.
  task automatic checkMicro(input string tag, input logic v, input logic m, input logic [2:0] r,
                            input logic [15:0] ofs, input logic last, input logic we);
    checkOutput({tag, ".valid"}, 16'(valid_d), 16'(v));
    checkOutput({tag, ".multi"}, 16'(multi_d), 16'(m));
    checkOutput({tag, ".mreg"}, 16'(mreg_d), 16'(r));
    checkOutput({tag, ".ofs"}, mem_ofs_d, ofs);
    checkOutput({tag, ".last"}, 16'(multi_last_d), 16'(last));
    checkOutput({tag, ".pc_we"}, 16'(pc_we), 16'(we));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(16'h0010, 16'h6AA1, 1'b0, 1'b0);
    #12;
    rst = 1'b0;
    tick();
    checkMicro("pre_rst_seq", 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-expansion, away from any clock edge.
    #2 rst = 1'b1;
    #1;
    checkMicro("rst", 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("rst.instr", instr_d, 16'h0000);
    checkOutput("rst.pc", pc_d, 16'h0000);
    checkOutput("rst.pc2", pc2_d, 16'h0000);
    #1 rst = 1'b0;

    applyStimulus(16'h0000, 16'h1050, 1'b0, 1'b0);
    tick();
    checkMicro("first", 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("first.instr", instr_d, 16'h1050);
    checkOutput("first.pc2", pc2_d, 16'h0002);

    applyStimulus(16'h0002, 16'h0283, 1'b0, 1'b0);
    tick();
    checkOutput("line2.instr", instr_d, 16'h0283);
    checkOutput("line2.pc", pc_d, 16'h0002);
    checkOutput("line2.pc_we", 16'(pc_we), 16'd1);
    applyStimulus(16'h0004, 16'h4A02, 1'b0, 1'b0);
    tick();
    checkOutput("line3.instr", instr_d, 16'h4A02);
    checkOutput("line3.pc", pc_d, 16'h0004);
    checkOutput("line3.multi", 16'(multi_d), 16'd0);

    // LM R5 with bitmap 0xA1 selects R0, R2, R7.
    applyStimulus(16'h0010, 16'h6AA1, 1'b0, 1'b0);
    tick();
    checkMicro("lm0", 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("lm0.pc", pc_d, 16'h0010);
    applyStimulus(16'h0012, 16'h1050, 1'b0, 1'b0);
    tick();
    checkMicro("lm1", 1'b1, 1'b1, 3'd2, 16'd2, 1'b0, 1'b0);
    checkOutput("lm1.pc", pc_d, 16'h0010);
    checkOutput("lm1.instr", instr_d, 16'h6AA1);

    applyStimulus(16'h0012, 16'h1050, 1'b1, 1'b0);
    #1 checkOutput("stall.pc_we", 16'(pc_we), 16'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkMicro("stall_hold", 1'b1, 1'b1, 3'd2, 16'd2, 1'b0, 1'b0);
    end
    applyStimulus(16'h0012, 16'h1050, 1'b0, 1'b0);
    tick();
    checkMicro("lm2", 1'b1, 1'b1, 3'd7, 16'd4, 1'b1, 1'b1);
    checkOutput("lm2.pc", pc_d, 16'h0010);
    tick();
    checkMicro("after_lm", 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("after_lm.instr", instr_d, 16'h1050);
    checkOutput("after_lm.pc", pc_d, 16'h0012);

    // SM with all eight registers, flushed on its first micro-op.
    applyStimulus(16'h0020, 16'h7EFF, 1'b0, 1'b0);
    tick();
    checkMicro("sm0", 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0);
    applyStimulus(16'h0022, 16'h0283, 1'b0, 1'b1);
    #1 checkOutput("flush.pc_we", 16'(pc_we), 16'd1);
    tick();
    applyStimulus(16'h0022, 16'h0283, 1'b0, 1'b0);
    #1;
    checkMicro("flushed", 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("flushed.instr", instr_d, 16'h0000);
    tick();
    checkOutput("post_flush.valid", 16'(valid_d), 16'd1);
    checkOutput("post_flush.instr", instr_d, 16'h0283);
    checkOutput("post_flush.pc", pc_d, 16'h0022);

    // Zero-bitmap SM becomes a bubble.
    applyStimulus(16'h0030, 16'h7800, 1'b0, 1'b0);
    tick();
    checkMicro("zero_bmp", 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    applyStimulus(16'h0032, 16'h1050, 1'b0, 1'b0);
    tick();
    checkMicro("after_zero", 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("after_zero.instr", instr_d, 16'h1050);
    checkOutput("after_zero.pc", pc_d, 16'h0032);

    // Single-register LM (bitmap 0x40 selects R1) is its own last micro-op.
    applyStimulus(16'h0034, 16'h6040, 1'b0, 1'b0);
    tick();
    checkMicro("lm_single", 1'b1, 1'b1, 3'd1, 16'd0, 1'b1, 1'b1);
    applyStimulus(16'h0036, 16'h4A02, 1'b0, 1'b0);
    tick();
    checkMicro("after_single", 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("after_single.instr", instr_d, 16'h4A02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifid_lmsm_expander.md
# ifid_lmsm_expander

IF/ID pipeline register for the IITB-RISC-23 pipeline, sitting directly downstream of the fetch stage and feeding decode. It captures the fetch stage's pc / pc+2 / instruction, and generates the fetch stage's PC write enable. It also expands each LM (opcode 4'b0110) and SM (opcode 4'b0111) into one micro-op per selected register, holding fetch until the expansion completes. Stall and flush from the hazard unit are applied here.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- pc_f  in  16  PC of fetched instruction
- pc2_f  in  16  pc_f + 2 from fetch
- instr_f  in  16  fetched instruction
- stall_in  in  1  decode/hazard stall; hold register contents
- flush  in  1  redirect in progress; squash held and incoming instruction
- pc_we  out  1  PC write enable to fetch stage
- valid_d  out  1  held micro-op is valid
- pc_d  out  16  PC of held instruction
- pc2_d  out  16  pc+2 of held instruction
- instr_d  out  16  held instruction word (unchanged across LM/SM micro-ops)
- multi_d  out  1  held micro-op belongs to LM/SM
- mreg_d  out  3  register index of current LM/SM micro-op
- mem_ofs_d  out  16  byte offset added to RA for current micro-op
- multi_last_d  out  1  current micro-op is last of its LM/SM

## Operation
- State register `seq_q`: NORMAL or SEQ. Also holds the remaining-register mask rem_q[7:0] and the offset counter ofs_q[15:0].
- Bitmap: instr[7:0]. Bit 7 selects R0, and bit (7-i) selects Ri. Expansion order is R0 upward, always the lowest-indexed remaining register first.
- Load of a new instruction (from IF):
  - Capture pc_f, pc2_f and instr_f. Set valid_d=1 and ofs_q=0.
  - If the opcode is LM/SM and the bitmap is nonzero: rem_q=bitmap, multi_d=1, go to SEQ if popcount>1, else stay NORMAL.
  - If LM/SM with bitmap 0: valid_d=0, multi_d=0, and the instruction is discarded as a no-op.
  - Otherwise multi_d=0 and rem_q=0.
- Outputs while multi_d=1:
  - mreg_d = index of the lowest-indexed set register in rem_q.
  - mem_ofs_d = ofs_q.
  - multi_last_d = (popcount(rem_q)==1).
- Outputs while multi_d=0: mreg_d=0, mem_ofs_d=0, multi_last_d=0.
- Per-cycle priority (highest first):
  1. flush: valid_d←0, multi_d←0, rem_q←0, ofs_q←0, seq_q←NORMAL, instr_d←0. pc_d/pc2_d are don't-care (cleared to 0). pc_we=1.
  2. stall_in: all registers hold; pc_we=0.
  3. SEQ and not last: clear the emitted bit in rem_q, ofs_q←ofs_q+2, instr_d/pc_d held. Go to NORMAL when the new popcount becomes 1. pc_we=0.
  4. Otherwise (NORMAL, or the last micro-op of SEQ): load a new instruction from IF; pc_we=1.
- pc_we is combinational from flush, stall_in, seq_q and rem_q only. It never depends on instr_f.
- ofs_q arithmetic: 16-bit unsigned, maximum value 14, so it never wraps.
- A bubble (valid_d=0) never enters SEQ.

## Timing
- Reset values while rst=1, asynchronous:
  - valid_d=0, pc_d=0, pc2_d=0, instr_d=0.
  - multi_d=0, mreg_d=0, mem_ofs_d=0, multi_last_d=0.
  - seq_q=NORMAL, rem_q=0, ofs_q=0.
  - pc_we = !stall_in.
- Latency: an instruction presented on instr_f in cycle n appears on instr_d in cycle n+1, given no stall or flush in cycle n.
- An LM/SM with k≥1 selected registers occupies *_d for exactly k unstalled cycles. pc_we=0 for the first k-1 of them.
- Stall cycles insert no gaps in the micro-op sequence and do not advance ofs_q.
- Flush on the last micro-op also discards instr_f in that cycle.
- rst asserted mid-SEQ aborts the expansion immediately. After release, the first rising edge loads from IF.

## Test plan
- Reset: assert rst mid-stream with stall_in=0. All *_d are 0 and pc_we=1 asynchronously. After release, pc_f=0x0000 / instr_f=0x1050 gives valid_d=1, instr_d=0x1050, pc2_d=0x0002 next cycle.
- Straight-line: instructions 0x1050, 0x0283, 0x4A02 at pc 0x0000/0x0002/0x0004. Each appears one cycle later with pc_we held at 1 and multi_d=0.
- LM expansion: instr_f=0x6AA1 (RA=R5, bitmap 0xA1) at pc 0x0010. Three cycles follow:
  - mreg 0 / ofs 0
  - mreg 2 / ofs 2
  - mreg 7 / ofs 4 / multi_last_d=1

  pc_d=0x0010 throughout. pc_we is 0 for two cycles, then 1.
- Stall in SEQ: during the second micro-op of the 0x6AA1 expansion, assert stall_in for 2 cycles. mreg_d=2 and mem_ofs_d=2 are held, and pc_we=0. Expansion resumes with mreg 7 / ofs 4.
- Flush in SEQ: assert flush during the first micro-op of SM 0x7EFF. Next cycle valid_d=0 and multi_d=0. pc_we=1 during the flush cycle. The following instruction loads normally.
- Zero bitmap: instr_f=0x7800 gives valid_d=0 for one cycle with pc_we=1. The next instruction follows without delay.
